// File: rtl/dma_pkg.sv
// Shared types and constants for the word-memory copy/fill engine.
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    FILL = 3'd4,
    DONE = 3'd5
  } dma_state_t;

  typedef enum logic {
    DMA_COPY = 1'b0,
    DMA_FILL = 1'b1
  } dma_mode_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_dma_copy.sv
// Bus initiator that copies or pattern-fills a block of 32-bit words over a
// single-port memory interface whose read data returns one cycle after the request.
module mem_dma_copy
  import dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  input  logic [31:0]      fill_data,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] remaining,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  dma_state_t  state;
  logic [31:0] src_ptr;
  logic [31:0] dst_ptr;
  logic [31:0] fill_q;

  // All bus outputs are registered; each transition pre-loads the values for the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      fill_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr & WORD_MASK;
            dst_ptr   <= dst_addr & WORD_MASK;
            fill_q    <= fill_data;
            remaining <= len_words;
            if (len_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (dma_mode_t'(mode) == DMA_FILL) begin
              state     <= FILL;
              busy      <= 1'b1;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_be    <= BE_WORD;
              mem_addr  <= dst_addr & WORD_MASK;
              mem_wdata <= fill_data;
            end else begin
              state    <= RD;
              busy     <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_be   <= '0;
              mem_addr <= src_addr & WORD_MASK;
            end
          end
        end
        RD: begin
          state   <= WAIT;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          mem_be  <= '0;
        end
        WAIT: begin
          // mem_wdata doubles as the captured read-data register.
          state     <= WR;
          mem_wdata <= mem_rdata;
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_be    <= BE_WORD;
          mem_addr  <= dst_ptr;
        end
        WR: begin
          src_ptr   <= src_ptr + 32'd4;
          dst_ptr   <= dst_ptr + 32'd4;
          remaining <= remaining - 1'b1;
          mem_we    <= 1'b0;
          mem_be    <= '0;
          if (remaining == LEN_W'(1)) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            mem_req <= 1'b0;
          end else begin
            state    <= RD;
            mem_req  <= 1'b1;
            mem_addr <= src_ptr + 32'd4;
          end
        end
        FILL: begin
          dst_ptr   <= dst_ptr + 32'd4;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_W'(1)) begin
            state   <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= '0;
          end else begin
            mem_addr  <= dst_ptr + 32'd4;
            mem_wdata <= fill_q;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          mem_be  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dma_copy.sv
// Randomized bench for mem_dma_copy: a 4 KiB RAM responder plus a cycle-trace model
// built from the command rules, compared against the bus every cycle.
module tb_mem_dma_copy;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             mode = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] len_words = '0;
  logic [31:0]      fill_data = '0;
  logic             busy, done, mem_req, mem_we;
  logic [LEN_W-1:0] remaining;
  logic [31:0]      mem_addr, mem_wdata;
  logic [3:0]       mem_be;
  logic [31:0]      mem_rdata = '0;

  mem_dma_copy #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
    .fill_data(fill_data), .busy(busy), .done(done), .remaining(remaining),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM responder: accepts every request, read data one cycle later.
  logic [31:0] ram [1024];
  always @(posedge clk) begin
    if (mem_req && mem_we) ram[mem_addr[11:2]] <= mem_wdata;
    if (mem_req && !mem_we) mem_rdata <= ram[mem_addr[11:2]];
  end

  typedef struct {
    bit          req;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          busy;
    bit          done;
    int          rem;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        tq[$];
  logic [31:0] mdl [1024];
  logic [31:0] mdl_save [1024];
  logic [31:0] wr_addrs[$];
  int          n_rd, n_wr, done_at;
  int          vectors = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Cycle-by-cycle expectation for one command, derived from the command rules.
  task automatic build(input bit m, input logic [31:0] s, input logic [31:0] d,
                       input int n, input logic [31:0] f);
    logic [31:0] sp, dp, w;
    int c;
    tq.delete();
    wr_addrs.delete();
    n_rd = 0;
    n_wr = 0;
    c = 1;
    sp = s & ~32'h3;
    dp = d & ~32'h3;
    for (int i = 0; i < n; i++) begin
      if (!m) begin
        tq.push_back('{1'b1, 1'b0, 4'h0, sp, 32'h0, 1'b1, 1'b0, n - i, c}); c++; n_rd++;
        tq.push_back('{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, n - i, c}); c++;
        w = mdl[sp[11:2]];
        sp = sp + 32'd4;
      end else begin
        w = f;
      end
      mdl[dp[11:2]] = w;
      tq.push_back('{1'b1, 1'b1, 4'hF, dp, w, 1'b1, 1'b0, n - i, c}); c++; n_wr++;
      wr_addrs.push_back(dp);
      dp = dp + 32'd4;
    end
    done_at = c;
    tq.push_back('{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b1, 0, c}); c++;
    tq.push_back('{1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 0, c});
  endtask

  // Single compare process: pops one expectation per cycle, sampled 2 time units after the edge.
  initial begin
    exp_t e;
    bit ok;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        ok = (mem_req === e.req) && (mem_we === e.we) && (mem_be === e.be) &&
             (busy === e.busy) && (done === e.done) && (int'(remaining) == e.rem);
        if (e.req && mem_addr !== e.addr) ok = 0;
        if (e.req && e.we && mem_wdata !== e.wdata) ok = 0;
        vectors++;
        if (!ok) begin
          errors++;
          $display("FAIL cycle%0d: got req=%b we=%b be=%h addr=%h wdata=%h busy=%b done=%b rem=%0d; want req=%b we=%b be=%h addr=%h wdata=%h busy=%b done=%b rem=%0d",
                   e.cyc, mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy, done, remaining,
                   e.req, e.we, e.be, e.addr, e.wdata, e.busy, e.done, e.rem);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, done}, 32'h0);
    chk({tag, "_rem"}, {16'h0, remaining}, 32'h0);
    chk({tag, "_req_we_be"}, {26'h0, mem_req, mem_we, mem_be}, 32'h0);
    chk({tag, "_addr"}, mem_addr, 32'h0);
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
  endtask

  task automatic run_cmd(input bit m, input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic [31:0] f, input bit ign, input bit mid_rst);
    int k;
    build(m, s, d, n, f);
    @(posedge clk); #1;
    start = 1'b1; mode = m; src_addr = s; dst_addr = d;
    len_words = LEN_W'(n); fill_data = f;
    @(posedge clk);
    exp_q = tq;
    #1;
    start = 1'b0; src_addr = $urandom; dst_addr = $urandom; fill_data = $urandom;
    len_words = LEN_W'($urandom); mode = $urandom_range(0, 1);
    if (ign) begin
      @(posedge clk); #1;
      start = 1'b1; mode = ~m; src_addr = 32'h0000_0800; dst_addr = 32'h0000_0900;
      len_words = LEN_W'(5); fill_data = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      start = 1'b0;
    end
    if (mid_rst) begin
      repeat (5) @(posedge clk);
      #3 rst = 1'b1;
      #1 check_reset_outputs("midrst");
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
    end
    k = 0;
    while (exp_q.size() > 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    vectors++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [31:0] s, d, f;
    int n;
    bit m;
    for (int i = 0; i < 1024; i++) begin
      ram[i] <= 32'h0;
      mdl[i] = 32'h0;
    end
    ram[0] <= 32'h1111_1111; ram[1] <= 32'h2222_2222;
    ram[2] <= 32'h3333_3333; ram[3] <= 32'h4444_4444;
    mdl[0] = 32'h1111_1111; mdl[1] = 32'h2222_2222;
    mdl[2] = 32'h3333_3333; mdl[3] = 32'h4444_4444;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst = 1'b0;

    // Basic copy of four words.
    run_cmd(1'b0, 32'h0, 32'h100, 4, 32'h0, 1'b0, 1'b0);
    chk("copy_done_cyc", done_at, 13);
    chk("copy_reads", n_rd, 4);
    chk("copy_writes", n_wr, 4);
    chk("copy_w0", ram[64], 32'h1111_1111);
    chk("copy_w3", ram[67], 32'h4444_4444);

    // Fill with unaligned destination.
    run_cmd(1'b1, 32'h0, 32'h203, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("fill_done_cyc", done_at, 4);
    chk("fill_reads", n_rd, 0);
    chk("fill_first_addr", wr_addrs[0], 32'h200);
    chk("fill_w2", ram[130], 32'hDEAD_BEEF);

    // Zero-length copy.
    run_cmd(1'b0, 32'h40, 32'h80, 0, 32'h0, 1'b0, 1'b0);
    chk("len0_done_cyc", done_at, 1);
    chk("len0_writes", n_wr, 0);

    // Start while busy is ignored.
    run_cmd(1'b0, 32'h100, 32'h300, 2, 32'h0, 1'b1, 1'b0);
    chk("ign_done_cyc", done_at, 7);
    chk("ign_w1", ram[193], 32'h2222_2222);

    // Address wrap.
    run_cmd(1'b1, 32'h0, 32'hFFFF_FFF8, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
    chk("wrap_addr2", wr_addrs[2], 32'h0000_0000);

    // Reset during the second write of a four-word copy.
    for (int i = 0; i < 1024; i++) mdl_save[i] = mdl[i];
    run_cmd(1'b0, 32'h100, 32'h400, 4, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 1024; i++) mdl[i] = mdl_save[i];
    mdl[256] = mdl_save[64];
    chk("rst_word0_written", ram[256], 32'h1111_1111);
    chk("rst_word1_untouched", ram[257], mdl_save[257]);
    run_cmd(1'b0, 32'h104, 32'h500, 1, 32'h0, 1'b0, 1'b0);
    chk("post_rst_copy", ram[320], 32'h2222_2222);

    // Randomized commands, overlapping regions allowed.
    for (int t = 0; t < 14; t++) begin
      m = $urandom_range(0, 1);
      s = {20'h0, 10'($urandom), 2'($urandom)};
      d = {20'h0, 10'($urandom), 2'($urandom)};
      n = $urandom_range(0, 8);
      f = $urandom;
      run_cmd(m, s, d, n, f, 1'b0, 1'b0);
      for (int i = 0; i < n; i++)
        chk("rand_mem", ram[10'(d[11:2] + 10'(i))], mdl[10'(d[11:2] + 10'(i))]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_dma_copy.md
Name: mem_dma_copy

Overview:
- Bus initiator for the SoC's single-port word memory interface: req/addr/we/be/wdata, with rdata returned one cycle after a read request.
- Drives the same signals that the on-chip RAM responds to.
- Copies a block of 32-bit words from a source address to a destination address, or fills a destination block with a constant pattern.
- Sits between the core-side control registers (start/config) and one RAM port. It is the master end of that interface.

Parameters:
- LEN_W, 16, width of the word-count input and the remaining-count output.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle command strobe; honoured only when busy=0
- mode  input  1  0=COPY, 1=FILL; sampled with start
- src_addr  input  32  source byte address; bits [1:0] ignored (treated as 0)
- dst_addr  input  32  destination byte address; bits [1:0] ignored
- len_words  input  LEN_W  number of words to transfer
- fill_data  input  32  pattern for FILL; sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when a command completes
- remaining  output  LEN_W  words not yet written
- mem_req  output  1  bus request
- mem_addr  output  32  word-aligned byte address, bits [1:0]=0
- mem_we  output  1  1=write, 0=read
- mem_be  output  4  byte enables; always 4'hF on writes, 4'h0 on reads
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid in the cycle after a read request

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, remaining=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Internal address/data registers are cleared.
- Interface timing: all mem_* outputs come from registered state and counters. No combinational path from mem_rdata to any output.
- Responder behaviour: the responder accepts every req in the same cycle and never stalls.
- FSM states: IDLE, RD, WAIT, WR, FILL, DONE.
- IDLE:
  - start=1 latches addresses (low bits zeroed), len, mode and fill_data.
  - len=0 -> DONE, with no bus activity.
  - mode=COPY -> RD.
  - mode=FILL -> FILL.
- RD: mem_req=1, mem_we=0, mem_addr=src_ptr. Next state WAIT.
- WAIT: mem_req=0. Capture mem_rdata into data_q at the end of this cycle. Next state WR.
- WR:
  - mem_req=1, mem_we=1, mem_be=4'hF, mem_addr=dst_ptr, mem_wdata=data_q.
  - At the end of the cycle: src_ptr+=4, dst_ptr+=4, remaining-=1.
  - Next state: remaining was 1 -> DONE; else -> RD.
- FILL:
  - mem_req=1, mem_we=1, mem_be=4'hF, mem_addr=dst_ptr, mem_wdata=fill_q. One word per cycle.
  - dst_ptr+=4 and remaining-=1 each cycle.
  - Leaves to DONE after the last word.
- DONE: done=1 for exactly one cycle, busy=0. Next state IDLE. A start arriving in DONE is ignored.
- Latency:
  - start accepted at cycle 0.
  - COPY of N words: first RD at cycle 1, done at cycle 3N+1.
  - FILL of N words: writes at cycles 1..N, done at cycle N+1.
  - len=0: done at cycle 1.
- Ignored start: start while busy=1 or in DONE is ignored and has no side effect on latched values.
- Pointer wrap: pointers wrap modulo 2^32 with no error (0xFFFFFFFC+4 -> 0x00000000).
- Overlap: copies are ascending only. Overlapping regions with dst>src produce a propagating copy; this is defined behaviour, not an error.
- remaining:
  - Loaded with len at start.
  - Decremented after each write.
  - Reads 0 in IDLE after completion.
- mem_wdata: holds its last value when mem_req=0. mem_be=0 whenever mem_we=0.
- Reset mid-transfer: returns to IDLE immediately. No done pulse. Outputs take their reset values asynchronously.

Decomposition:
- Shared package dma_pkg:
  - state enum dma_state_t {IDLE, RD, WAIT, WR, FILL, DONE}.
  - mode enum dma_mode_t {DMA_COPY=0, DMA_FILL=1}.
  - constant BE_WORD=4'hF.
- No sub-module. The block is a single FSM with counters; the RAM is instantiated only in the bench as the responder.

Test Plan:
- COPY: preload RAM[0x000..0x00C] with 0x11111111, 0x22222222, 0x33333333, 0x44444444; start with src=0x000, dst=0x100, len=4. Expect RAM[0x100..0x10C] to match, done at cycle 13, exactly 4 reads and 4 writes, mem_be=4'hF on every write.
- FILL: dst=0x203 (low bits ignored), len=3, fill=0xDEADBEEF. Expect writes to 0x200, 0x204, 0x208 at cycles 1-3, done at cycle 4, no reads.
- len=0, COPY mode: expect done at cycle 1, mem_req never asserted, busy high for zero cycles.
- start pulsed at cycle 2 of a len=2 COPY with different src/dst/len: ignored; the original transfer completes unchanged and done fires once at cycle 7.
- Wrap: FILL with dst=0xFFFFFFF8, len=3. Expect addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst asserted during WR of word 2 of a len=4 COPY: all outputs go to reset values immediately, no done pulse, remaining=0; a subsequent start with len=1 completes normally.
